// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: 33 edges start-to-write, 1 edge for divide-by-zero.
// Define MULDIV_EARLY_OUT_EN to let multiply leave CALC once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mt_we,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam int W2 = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [W2-1:0]    a_q, a_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_in;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] rem_sub;
  logic             mul_last, calc_last;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign signed_in = ~op[0];
  assign rs_mag    = (signed_in && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign rt_mag    = (signed_in && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Divide keeps {remainder, dividend/quotient} in p_q; partial is the shifted-in trial remainder.
  assign partial = p_q[W2-1:WIDTH-1];
  assign rem_sub = partial[WIDTH-1:0] - b_q;

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (b_q[WIDTH-1:1] == '0);
`else
  assign mul_last = 1'b0;
`endif
  assign calc_last = (count_q == 6'd31) || (!div_q && mul_last);

  assign prod_fix = neg_q  ? -p_q              : p_q;
  assign quo_fix  = neg_q  ? -p_q[WIDTH-1:0]   : p_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -p_q[W2-1:WIDTH]  : p_q[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mt_we) begin
          if (mt_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
        if (start) begin
          div_d   = op[1];
          count_d = '0;
          neg_d   = signed_in & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          rneg_d  = signed_in & rs_data[WIDTH-1];
          a_d     = {{WIDTH{1'b0}}, rs_mag};
          b_d     = rt_mag;
          p_d     = '0;
          state_d = S_CALC;
          if (op[1]) begin
            p_d = {{WIDTH{1'b0}}, rs_mag};
            // Divide by zero skips CALC; SIGN passes the raw dividend through unsigned.
            if (rt_data == '0) begin
              p_d     = {rs_data, {WIDTH{1'b1}}};
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_SIGN;
            end
          end
        end
      end
      S_CALC: begin
        count_d = count_q + 6'd1;
        if (div_q) begin
          if (partial >= {1'b0, b_q}) p_d = {rem_sub, p_q[WIDTH-2:0], 1'b1};
          else                        p_d = {p_q[W2-2:0], 1'b0};
        end else begin
          if (b_q[0]) p_d = p_q + a_q;
          a_d = {a_q[W2-2:0], 1'b0};
          b_d = b_q >> 1;
        end
        if (calc_last) state_d = S_SIGN;
      end
      S_SIGN: begin
        hi_d    = div_q ? rem_fix : prod_fix[W2-1:WIDTH];
        lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = mf_sel ? hi_q : lo_q;
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It consumes operands and the decoded op from the ID/EX pipeline register outputs: rs data, rt data, and the function-field decode. It computes MULT/MULTU/DIV/DIVU results into architectural HI/LO registers over multiple cycles. While it works, it asserts `busy` so the hazard unit stalls IF/ID and injects bubbles into ID/EX.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  launch the op on `op`, `rs_data`, `rt_data`; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  32  multiplicand / dividend (ID/EX RdData1).
- `rt_data`  in  32  multiplier / divisor (ID/EX RdData2).
- `mt_we`  in  1  MTHI/MTLO write strobe.
- `mt_sel`  in  1  write target: 1 = HI, 0 = LO.
- `mt_data`  in  32  MTHI/MTLO data.
- `mf_sel`  in  1  read select for `mf_data`: 1 = HI, 0 = LO.
- `busy`  out  1  state != IDLE; drives the stall request.
- `done`  out  1  one-cycle pulse, high the cycle after HI/LO are written.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mf_data`  out  32  combinational `mf_sel ? hi : lo`.

## Operation
- States:
  - IDLE.
  - CALC: iterative, 6-bit `count`.
  - SIGN: sign fix-up and HI/LO write.
- IDLE + `start`:
  - Latch `op`.
  - For signed ops, latch operand magnitudes and the result signs: product sign = sign(rs) ^ sign(rt); remainder sign = sign(rs).
  - Set `count` = 0 and go to CALC.
- IDLE + `start` on DIV/DIVU with `rt_data` == 0:
  - Go directly to SIGN.
  - HI = `rs_data` unmodified, LO = 32'hFFFF_FFFF.
- CALC, multiply:
  - Radix-2 shift-add into a 64-bit product.
  - One multiplier bit per cycle, 32 iterations.
- CALC, divide:
  - Restoring divide, one quotient bit per cycle, 32 iterations.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- CALC exits to SIGN on the edge completing iteration 32 (`count` == 31).
- SIGN:
  - Negate the product, quotient and remainder as required.
  - Write HI = upper product or remainder; LO = lower product or quotient.
  - Go to IDLE; set `done` = 1 for the following cycle.
- `start` while `busy` is ignored. The hazard unit must hold the instruction.
- `mt_we` in IDLE: writes HI or LO at the edge.
- `mt_we` while `busy`: dropped.
- `mt_we` coincident with a SIGN write: cannot occur, because SIGN != IDLE.
- Arithmetic: the most-negative operand magnitude is 2^31, held as unsigned 32-bit.
- DIV 0x8000_0000 / 0xFFFF_FFFF yields LO = 0x8000_0000, HI = 0.

## Timing
- Reset, asynchronous: state = IDLE, `count` = 0, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
- Reset asserted mid-CALC or in SIGN aborts the op; HI/LO clear to 0.
- `start` sampled at edge N:
  - `busy` is high from after N through edge N+33.
  - HI/LO are updated at edge N+33.
  - `done` is high for the cycle between N+33 and N+34.
- Divide by zero: SIGN at edge N+1, so HI/LO are written at N+1 and `done` is high after N+1.
- `done` is never high while `busy` is high.
- Back-to-back: `start` at edge N+33 is ignored (still SIGN); the earliest new start is edge N+34.
- `mf_data` reflects HI/LO in the same cycle as their update edge; no bypass of in-flight results.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Multiply leaves CALC on the edge where the remaining unshifted multiplier magnitude becomes zero.
  - The minimum is 1 iteration.
  - Zero multiplier: 1 iteration, so HI/LO are written at edge N+2.
  - Divide is unaffected.
- Undefined: multiply always takes 32 iterations.

## Test plan
- MULT rs=0xFFFF_FFFD (-3), rt=7, start at edge N:
  - HI=0xFFFF_FFFF, LO=0xFFFF_FFEB at N+33.
  - `busy` high for 33 cycles; `done` single pulse.
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFF_FFF9 (-7) / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 0x1234/0 -> HI=0x1234, LO=0xFFFF_FFFF at N+1, `done` after N+1.
- Held `start` with a new op during `busy`, plus `mt_we` during `busy` -> both ignored; the first op's result is intact.
- MTLO 0xA5A5_A5A5 in IDLE -> `mf_data` (`mf_sel`=0) = 0xA5A5_A5A5.
- Reset asserted at N+10 of a MULTU -> immediate IDLE, HI=LO=0, no `done`.
- With `MULDIV_EARLY_OUT_EN`: MULTU 5*3 -> LO=15, HI=0 at edge N+3 (2 iterations).
- Without `MULDIV_EARLY_OUT_EN`: the same op writes at N+33.
